// File: rtl/ark_stream.sv
// ark_stream: folded AddRoundKey stage. It XORs one SLICE_W slice of state and key per clock.
// Defining ARK_PARITY_EN adds per-byte parity prediction and checking (out_par, par_err).
module ark_stream #(
   parameter int DATA_W  = 128,
   parameter int SLICE_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] state_in,
   input  logic [DATA_W-1:0] round_key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] state_out,
   output logic              busy
`ifdef ARK_PARITY_EN
   ,
   output logic [DATA_W/8-1:0] out_par,
   output logic                par_err
`endif
);

   localparam int BEATS = DATA_W / SLICE_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_work;
   logic [DATA_W-1:0] r_key;
   logic [DATA_W-1:0] r_out;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_out_valid;
   logic              r_busy;
   logic [DATA_W-1:0] w_work_next;
   logic              w_accept;

`ifdef ARK_PARITY_EN
   localparam int NBYTES = DATA_W / 8;

   logic [NBYTES-1:0] r_pred;
   logic [NBYTES-1:0] r_out_par;
   logic              r_par_err;

   function automatic logic [NBYTES-1:0] byte_parity(input logic [DATA_W-1:0] d);
      logic [NBYTES-1:0] p;
      p = '0;
      for (int i = 0; i < NBYTES; i++) begin
         p[i] = ^d[i*8 +: 8];
      end
      return p;
   endfunction
`endif

   generate
      if ((DATA_W % 8 != 0) || (SLICE_W % 8 != 0) || (DATA_W % SLICE_W != 0)) begin : g_bad_param
         $error("ark_stream: DATA_W and SLICE_W must be multiples of 8 and SLICE_W must divide DATA_W");
      end
   endgenerate

   // Only the slice selected by r_cnt is XORed this beat; all other slices pass through.
   for (genvar b = 0; b < BEATS; b++) begin : g_slice
      assign w_work_next[b*SLICE_W +: SLICE_W] = (r_cnt == CNT_W'(b))
         ? (r_work[b*SLICE_W +: SLICE_W] ^ r_key[b*SLICE_W +: SLICE_W])
         : r_work[b*SLICE_W +: SLICE_W];
   end

   // in_ready depends only on registered state and out_ready.
   assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
   assign w_accept = in_valid && in_ready;

   // Control FSM plus datapath registers. A DONE->BUSY transfer reloads on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_work      <= '0;
         r_key       <= '0;
         r_out       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`ifdef ARK_PARITY_EN
         r_pred      <= '0;
         r_out_par   <= '0;
         r_par_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_BUSY;
                  r_busy  <= 1'b1;
               end
            end
            S_BUSY: begin
               r_work <= w_work_next;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST) begin
                  r_state     <= S_DONE;
                  r_out       <= w_work_next;
                  r_out_valid <= 1'b1;
`ifdef ARK_PARITY_EN
                  r_out_par   <= byte_parity(w_work_next);
                  r_par_err   <= |(byte_parity(w_work_next) ^ r_pred);
`endif
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
`ifdef ARK_PARITY_EN
                  r_par_err   <= 1'b0;
`endif
                  if (w_accept) begin
                     r_state <= S_BUSY;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase

         if (w_accept) begin
            r_work <= state_in;
            r_key  <= round_key;
            r_cnt  <= '0;
`ifdef ARK_PARITY_EN
            r_pred <= byte_parity(state_in) ^ byte_parity(round_key);
`endif
         end
      end
   end

   assign out_valid = r_out_valid;
   assign state_out = r_out;
   assign busy      = r_busy;
`ifdef ARK_PARITY_EN
   assign out_par   = r_out_par;
   assign par_err   = r_par_err;
`endif

endmodule
